// File: rtl/arty_pkg.sv
// Shared board types for the Arty slice: scratch-memory addressing/storage
// plus the arbitration types used by mem_arbiter.
package arty_pkg;

    localparam int MemDepth = 8;
    localparam int MaxReq   = 4;

    typedef logic [2:0]                 MemAddr;
    typedef logic [7:0]                 MemDataT;
    typedef MemDataT [MemDepth-1:0]     MemType;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } ArbStateT;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational grantee selection for mem_arbiter: round-robin after `last`,
// or lowest-index-wins when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick
    import arty_pkg::*;
#(
    parameter int NumReq = 2,
    parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   last,
    output logic [IdxW-1:0]   idx,
    output logic              valid
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IdxW'(i);
                valid = 1'b1;
            end
        end
    end
`else
    // cand[k] is the index examined k+1 places after the previous grantee.
    logic [IdxW-1:0] cand [NumReq];

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_cand
            assign cand[gi] = IdxW'((int'(last) + gi + 1) % NumReq);
        end
    endgenerate

    // Descending scan so the nearest candidate overrides the farther ones.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                idx   = cand[i];
                valid = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Req/ack arbiter owning the 8-byte scratch memory; IDLE -> ACCESS -> ACK.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module mem_arbiter
    import arty_pkg::*;
#(
    parameter  int      NumReq    = 2,
    parameter  MemDataT ResetByte = 8'h00,
    localparam int      IdxW      = $clog2(NumReq)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NumReq-1:0]     req_i,
    input  logic [NumReq-1:0]     we_i,
    input  MemAddr [NumReq-1:0]   addr_i,
    input  MemDataT [NumReq-1:0]  wdata_i,
    output logic [NumReq-1:0]     ack_o,
    output MemDataT               rdata_o,
    output logic [IdxW-1:0]       gnt_id_o,
    output logic                  busy_o,
    output MemType                mem_o
);

    generate
        if (NumReq < 2 || NumReq > MaxReq) begin : g_bad_numreq
            $error("mem_arbiter: NumReq must be in 2..%0d", MaxReq);
        end
    endgenerate

    ArbStateT          state_reg;
    logic [IdxW-1:0]   gnt_reg;
    logic [NumReq-1:0] ack_reg;
    MemDataT           rdata_reg;
    MemType            mem_reg;

    logic [IdxW-1:0]   pick_idx;
    logic              pick_valid;
    logic [IdxW-1:0]   pick_last;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign pick_last = '0;
`else
    logic [IdxW-1:0]   last_reg;
    assign pick_last = last_reg;
`endif

    rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_pick (
        .req   (req_i),
        .last  (pick_last),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            ack_reg   <= '0;
            rdata_reg <= '0;
            mem_reg   <= {MemDepth{ResetByte}};
`ifndef MEM_ARB_FIXED_PRIO_EN
            // Start "after" the last index so requester 0 wins the first tie.
            last_reg  <= IdxW'(NumReq - 1);
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= '0;
                    if (pick_valid) begin
                        gnt_reg   <= pick_idx;
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_i[gnt_reg]) begin
                        mem_reg[addr_i[gnt_reg]] <= wdata_i[gnt_reg];
                        rdata_reg                <= wdata_i[gnt_reg];
                    end else begin
                        rdata_reg <= mem_reg[addr_i[gnt_reg]];
                    end
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_reg <= gnt_reg;
`endif
                    ack_reg          <= '0;
                    ack_reg[gnt_reg] <= 1'b1;
                    state_reg        <= ACK;
                end
                ACK: begin
                    ack_reg   <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    ack_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ack_o    = ack_reg;
    assign rdata_o  = rdata_reg;
    assign gnt_id_o = gnt_reg;
    assign busy_o   = (state_reg != IDLE);
    assign mem_o    = mem_reg;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the 8-byte board scratch memory (MemType, MemAddr-addressed, 8-bit words).
- Shares it between NumReq requesters (index 0 = JTAG debug port, 1 = button/switch UI, others spare).
- Uses a req/ack handshake with round-robin arbitration.
- Exports the full memory contents so the LED driver can display any byte without arbitration.

Parameters:
- NumReq, 2, number of requesters; legal range 2..4.
- ResetByte, 8'h00, value loaded into every memory byte on reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_i  in  NumReq  per-requester access request
- we_i  in  NumReq  per-requester write enable (1 = write, 0 = read)
- addr_i  in  NumReq x MemAddr  per-requester byte address
- wdata_i  in  NumReq x 8  per-requester write data
- ack_o  out  NumReq  one-cycle completion pulse, one-hot
- rdata_o  out  8  read data, valid only while an ack_o bit is high
- gnt_id_o  out  $clog2(NumReq)  index of the current or most recent grantee
- busy_o  out  1  high whenever the FSM is not in IDLE
- mem_o  out  MemType  live memory contents, registered

Behaviour:
- Reset (asynchronous, active-high):
  - Memory: all bytes = ResetByte.
  - Outputs: ack_o = 0, rdata_o = 0, busy_o = 0, gnt_id_o = 0.
  - State: FSM = IDLE; round-robin pointer last_q = NumReq-1, so requester 0 wins the first tie.
- FSM states: IDLE -> ACCESS -> ACK -> IDLE.
  - IDLE: if any req_i bit is high, select the grantee and latch its index into gnt_q; go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: operate on addr_i[gnt_q].
    - Write (we_i[gnt_q] = 1): mem[addr] <= wdata_i[gnt_q]; rdata_o <= wdata_i[gnt_q].
    - Read: rdata_o <= mem[addr].
    - Set last_q <= gnt_q. Go to ACK.
  - ACK: ack_o[gnt_q] = 1 for exactly this cycle. Go to IDLE.
- Latency and throughput:
  - Request first seen high in IDLE at cycle N: ack at cycle N+2.
  - Write data is visible on mem_o from cycle N+2.
  - Maximum throughput: one transaction per 3 cycles.
- Requester rules:
  - Hold req_i, we_i, addr_i and wdata_i stable from assertion through its ack cycle.
  - Deassert req_i in the cycle after ack, or keep it high to request again.
  - A held req_i re-enters arbitration in the next IDLE cycle.
- Round-robin selection: search indices last_q+1, last_q+2, … modulo NumReq; the first requester with req_i high wins.
- Simultaneous requests: requesters alternate strictly; none is granted twice in a row while another is waiting.
- Non-grantee inputs are ignored; a non-grantee changing its request mid-transaction has no effect.
- A grantee dropping req_i after IDLE sampled it: the transaction still completes and the ack is still issued. This is a protocol error and is not checked.
- rdata_o holds its last value outside ACK.
- mem_o is a direct copy of the storage registers and changes only in ACCESS on a write.
- Reset asserted mid-transaction: immediate return to IDLE, no ack issued, memory reinitialised.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest index with req_i high always wins. last_q is not implemented, so the debug port can starve the UI.
- Undefined (default): round-robin as described under Behaviour.

Decomposition:
- Additions to arty_pkg:
  - MemDataT = logic [7:0].
  - Enum ArbStateT {IDLE, ACCESS, ACK}.
  - MaxReq = 4.
- Reuse the existing MemAddr / MemType types for address and storage.
- Sub-module rr_pick (combinational):
  - Inputs: req vector, last index.
  - Output: grantee index plus a valid flag.
  - Contains the MEM_ARB_FIXED_PRIO_EN switch.
  - Unit-testable on its own.

Test Plan:
- Reset, then idle -> mem_o = all 8'h00, ack_o = 0, busy_o = 0, rdata_o = 0.
- Requester 0 writes addr 3, data 8'hA5 (req at cycle N) -> ack_o = 2'b01 at N+2; mem_o byte 3 = 8'hA5 from N+2.
- Requester 1 reads addr 3 after the previous write -> ack_o = 2'b10 two cycles after req; rdata_o = 8'hA5 in the ack cycle.
- Both requesters hold req continuously, writing distinct addresses -> acks alternate 01, 10, 01, 10, each 3 cycles apart; first ack goes to requester 0.
  - With MEM_ARB_FIXED_PRIO_EN defined: every ack = 01.
- Write addr 7 = 8'hFF, then read addr 7 -> rdata_o = 8'hFF (highest-address boundary); addr 0 is unaffected.
- Assert reset during ACCESS of a write (addr 2, 8'h3C) -> no ack; mem_o byte 2 = 8'h00; FSM in IDLE on the first cycle after reset release.
